// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Bundle between the raster timing generator and the VGA display stage.
//   Signals:
//     pixel_en       pixel-rate clock enable into the generator
//     vga_h_sync     horizontal sync, active low
//     vga_v_sync     vertical sync, active low
//     inDisplayArea  current pixel is visible
//     CounterX       pixel column
//     CounterY       line
//     line_tick      one-clk strobe at the start of each line
//     frame_tick     one-clk strobe at the start of vertical blanking
//     frame_count    frame counter (zero unless VGA_FRAME_COUNT_EN)
//   Modports:
//     master  timing generator side (drives timing, receives pixel_en)
//     slave   display / consumer side
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
  logic        pixel_en;
  logic        vga_h_sync;
  logic        vga_v_sync;
  logic        inDisplayArea;
  logic [9:0]  CounterX;
  logic [9:0]  CounterY;
  logic        line_tick;
  logic        frame_tick;
  logic [15:0] frame_count;

  modport master (
    input  pixel_en,
    output vga_h_sync, vga_v_sync, inDisplayArea,
    output CounterX, CounterY, line_tick, frame_tick, frame_count
  );

  modport slave (
    output pixel_en,
    input  vga_h_sync, vga_v_sync, inDisplayArea,
    input  CounterX, CounterY, line_tick, frame_tick, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator feeding the VGA display stage. Produces sync
//   pulses, pixel coordinates, the visible-area qualifier and one-clk line /
//   frame strobes. Pixel rate comes from the pixel_en clock enable.
//   Ports:
//     clk      system clock
//     reset_n  synchronous active-low reset
//     vga      vga_timing_gen_if.master (pixel_en in, all timing outputs)
//   Optional feature macro: VGA_FRAME_COUNT_EN
//     defined   -> frame_count increments with each frame_tick (wraps 16 bits)
//     undefined -> frame_count tied to zero, no register built
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_total
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
    end
  endgenerate

  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS        = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_h_sync;
  logic       r_v_sync;
  logic       r_disp;
  logic       r_line_tick;
  logic       r_frame_tick;

  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_h_sync_nxt;
  logic       w_v_sync_nxt;
  logic       w_disp_nxt;
  logic       w_line_tick_nxt;
  logic       w_frame_tick_nxt;

  // Outputs are decoded from the next-state counters so that every registered
  // output lines up with the coordinates presented in the same cycle.
  always_comb begin
    w_x_nxt = r_x + 10'd1;
    w_y_nxt = r_y;
    if (r_x == H_LAST) begin
      w_x_nxt = '0;
      w_y_nxt = (r_y == V_LAST) ? '0 : r_y + 10'd1;
    end
    w_h_sync_nxt     = !((w_x_nxt >= H_SYNC_FIRST) && (w_x_nxt <= H_SYNC_LAST));
    w_v_sync_nxt     = !((w_y_nxt >= V_SYNC_FIRST) && (w_y_nxt <= V_SYNC_LAST));
    w_disp_nxt       = (w_x_nxt < H_VIS) && (w_y_nxt < V_VIS);
    w_line_tick_nxt  = (w_x_nxt == '0);
    w_frame_tick_nxt = (w_x_nxt == '0) && (w_y_nxt == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_x          <= '0;
      r_y          <= '0;
      r_h_sync     <= 1'b1;
      r_v_sync     <= 1'b1;
      r_disp       <= 1'b0;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else if (vga.pixel_en) begin
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_h_sync     <= w_h_sync_nxt;
      r_v_sync     <= w_v_sync_nxt;
      r_disp       <= w_disp_nxt;
      r_line_tick  <= w_line_tick_nxt;
      r_frame_tick <= w_frame_tick_nxt;
    end else begin
      // Strobes must not stretch across enable-low cycles.
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (vga.pixel_en && w_frame_tick_nxt) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign vga.frame_count = r_frame_count;
`else
  assign vga.frame_count = '0;
`endif

  assign vga.CounterX      = r_x;
  assign vga.CounterY      = r_y;
  assign vga.vga_h_sync    = r_h_sync;
  assign vga.vga_v_sync    = r_v_sync;
  assign vga.inDisplayArea = r_disp;
  assign vga.line_tick     = r_line_tick;
  assign vga.frame_tick    = r_frame_tick;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Two instances share clk / reset_n / pixel_en: one with default 640x480
//   timing for line-level vectors, one with a small raster (32 x 20, visible
//   16 x 12, hsync cols 20..25, vsync lines 14..15) for whole-frame behaviour.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk;
  logic reset_n;
  logic pixel_en;

  int unsigned n_assert;
  int unsigned n_fail;

  vga_timing_gen_if vd ();
  vga_timing_gen_if vsm ();

  assign vd.pixel_en  = pixel_en;
  assign vsm.pixel_en = pixel_en;

  vga_timing_gen u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vd)
  );

  vga_timing_gen #(
    .H_ACTIVE (16),
    .H_FP     (4),
    .H_SYNC   (6),
    .H_BP     (6),
    .V_ACTIVE (12),
    .V_FP     (2),
    .V_SYNC   (2),
    .V_BP     (4)
  ) u_small (
    .clk     (clk),
    .reset_n (reset_n),
    .vga     (vsm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view: {x, y, hs, vs, de, line_tick, frame_tick, frame_count}
  typedef logic [40:0] obs_t;

  function automatic obs_t pack_d();
    return {vd.CounterX, vd.CounterY, vd.vga_h_sync, vd.vga_v_sync,
            vd.inDisplayArea, vd.line_tick, vd.frame_tick, vd.frame_count};
  endfunction

  function automatic obs_t pack_s();
    return {vsm.CounterX, vsm.CounterY, vsm.vga_h_sync, vsm.vga_v_sync,
            vsm.inDisplayArea, vsm.line_tick, vsm.frame_tick, vsm.frame_count};
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b de=%b lt=%b ft=%b fc=%0d",
                     v[40:31], v[30:21], v[20], v[19], v[18], v[17], v[16], v[15:0]);
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %s, expected %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- default-timing vector table ----------------
  typedef struct {
    string       name;
    logic        rst_n;
    logic        en;
    int unsigned n;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        de;
    logic        lt;
    logic        ft;
  } vec_t;

  localparam int unsigned NVEC = 15;
  vec_t vecs [NVEC];

  // ---------------- small-raster reference model ----------------
  int          mx, my;
  logic        mhs, mvs, mde, mlt, mft;
  logic [15:0] mfc;

  int unsigned agg_lt, agg_ft, agg_dbl;
  int          vs_lo_min, vs_lo_max, ft_x, ft_y;
  logic        prev_lt, prev_ft;

  function automatic obs_t model_pack();
    return {10'(mx), 10'(my), mhs, mvs, mde, mlt, mft, mfc};
  endfunction

  task automatic model_reset();
    mx = 0; my = 0;
    mhs = 1'b1; mvs = 1'b1; mde = 1'b0; mlt = 1'b0; mft = 1'b0;
    mfc = '0;
  endtask

  task automatic clear_agg();
    agg_lt = 0; agg_ft = 0; agg_dbl = 0;
    vs_lo_min = 1023; vs_lo_max = -1;
    ft_x = -1; ft_y = -1;
    prev_lt = 1'b0; prev_ft = 1'b0;
  endtask

  task automatic small_cycle(input logic en);
    pixel_en = en;
    step();
    if (en) begin
      if (mx == 31) begin
        mx = 0;
        my = (my == 19) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      mhs = !((mx >= 20) && (mx <= 25));
      mvs = !((my >= 14) && (my <= 15));
      mde = (mx < 16) && (my < 12);
      mlt = (mx == 0);
      mft = (mx == 0) && (my == 12);
`ifdef VGA_FRAME_COUNT_EN
      if (mft) mfc = mfc + 16'd1;
`endif
    end else begin
      mlt = 1'b0;
      mft = 1'b0;
    end
    check("small_cycle", pack_s(), model_pack());
    if (vsm.line_tick) agg_lt++;
    if (vsm.frame_tick) begin
      agg_ft++;
      ft_x = int'(vsm.CounterX);
      ft_y = int'(vsm.CounterY);
    end
    if ((vsm.line_tick && prev_lt) || (vsm.frame_tick && prev_ft)) agg_dbl++;
    prev_lt = vsm.line_tick;
    prev_ft = vsm.frame_tick;
    if (!vsm.vga_v_sync) begin
      if (int'(vsm.CounterY) < vs_lo_min) vs_lo_min = int'(vsm.CounterY);
      if (int'(vsm.CounterY) > vs_lo_max) vs_lo_max = int'(vsm.CounterY);
    end
  endtask

  task automatic small_reset(input string name);
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    step();
    check(name, pack_s(), {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0});
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    pixel_en = 1'b0;

    //            name          rst  en   n    x        y      hs vs de lt ft
    vecs[0]  = '{"reset_hold",  1'b0, 1'b1, 2,  10'd0,   10'd0, 1, 1, 0, 0, 0};
    vecs[1]  = '{"first_en",    1'b1, 1'b1, 1,  10'd1,   10'd0, 1, 1, 1, 0, 0};
    vecs[2]  = '{"last_vis",    1'b1, 1'b1, 638, 10'd639, 10'd0, 1, 1, 1, 0, 0};
    vecs[3]  = '{"de_fall",     1'b1, 1'b1, 1,  10'd640, 10'd0, 1, 1, 0, 0, 0};
    vecs[4]  = '{"pre_hsync",   1'b1, 1'b1, 15, 10'd655, 10'd0, 1, 1, 0, 0, 0};
    vecs[5]  = '{"hsync_first", 1'b1, 1'b1, 1,  10'd656, 10'd0, 0, 1, 0, 0, 0};
    vecs[6]  = '{"hsync_last",  1'b1, 1'b1, 95, 10'd751, 10'd0, 0, 1, 0, 0, 0};
    vecs[7]  = '{"hsync_end",   1'b1, 1'b1, 1,  10'd752, 10'd0, 1, 1, 0, 0, 0};
    vecs[8]  = '{"pre_wrap",    1'b1, 1'b1, 46, 10'd798, 10'd0, 1, 1, 0, 0, 0};
    vecs[9]  = '{"line_end",    1'b1, 1'b1, 1,  10'd799, 10'd0, 1, 1, 0, 0, 0};
    vecs[10] = '{"en_low_hold", 1'b1, 1'b0, 3,  10'd799, 10'd0, 1, 1, 0, 0, 0};
    vecs[11] = '{"line_wrap",   1'b1, 1'b1, 1,  10'd0,   10'd1, 1, 1, 1, 1, 0};
    vecs[12] = '{"tick_nostr",  1'b1, 1'b0, 1,  10'd0,   10'd1, 1, 1, 1, 0, 0};
    vecs[13] = '{"after_wrap",  1'b1, 1'b1, 1,  10'd1,   10'd1, 1, 1, 1, 0, 0};
    vecs[14] = '{"reset_mid",   1'b0, 1'b1, 1,  10'd0,   10'd0, 1, 1, 0, 0, 0};

    for (int unsigned i = 0; i < NVEC; i++) begin
      reset_n  = vecs[i].rst_n;
      pixel_en = vecs[i].en;
      for (int unsigned k = 0; k < vecs[i].n; k++) step();
      check(vecs[i].name, pack_d(),
            {vecs[i].x, vecs[i].y, vecs[i].hs, vecs[i].vs, vecs[i].de,
             vecs[i].lt, vecs[i].ft, 16'd0});
    end

    // Full frame on the small raster.
    small_reset("small_reset");
    clear_agg();
    for (int i = 0; i < 640; i++) small_cycle(1'b1);
    check_int("frame_tick_count", int'(agg_ft), 1);
    check_int("frame_tick_x", ft_x, 0);
    check_int("frame_tick_y", ft_y, 12);
    check_int("line_tick_count", int'(agg_lt), 20);
    check_int("vsync_first_line", vs_lo_min, 14);
    check_int("vsync_last_line", vs_lo_max, 15);
    check_int("frame_end_x", int'(vsm.CounterX), 0);
    check_int("frame_end_y", int'(vsm.CounterY), 0);

    // Enable toggling: half-rate advance, single-clk strobes.
    clear_agg();
    for (int i = 0; i < 256; i++) small_cycle((i % 2) == 0);
    check_int("gated_tick_stretch", int'(agg_dbl), 0);
    check_int("gated_line_ticks", int'(agg_lt), 4);
    check_int("gated_x", int'(vsm.CounterX), 0);
    check_int("gated_y", int'(vsm.CounterY), 4);

    // Mid-frame reset, then no early frame tick on the restarted frame.
    small_reset("reset_before_mid");
    for (int i = 0; i < 234; i++) small_cycle(1'b1);
    check_int("midframe_x", int'(vsm.CounterX), 10);
    check_int("midframe_y", int'(vsm.CounterY), 7);
    small_reset("midframe_reset");
    clear_agg();
    for (int i = 0; i < 383; i++) small_cycle(1'b1);
    check_int("no_early_frame_tick", int'(agg_ft), 0);
    small_cycle(1'b1);
    check_int("restart_frame_tick", int'(agg_ft), 1);

    // Three frames from reset for frame_count.
    small_reset("reset_before_count");
    for (int i = 0; i < 1920; i++) small_cycle(1'b1);
`ifdef VGA_FRAME_COUNT_EN
    check_int("frame_count_3", int'(vsm.frame_count), 3);
`else
    check_int("frame_count_0", int'(vsm.frame_count), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
